// File: rtl/move_cmd_scheduler_if.sv
// ---------------------------------------------------------------------------
// move_cmd_scheduler_if
// Groups the handshake/bus signals around the move command scheduler.
//   req_auto_*  : auto tracker request (valid/x/y in, ready out of scheduler)
//   req_man_*   : manual jog request   (valid/x/y in, ready out of scheduler)
//   cmd_*       : command to the head-motion engine (valid/x/y out, ready in)
//   move_done   : one-cycle completion pulse from the motion engine
// Modports:
//   slave  : the scheduler's view (consumes requests, produces commands)
//   master : the surrounding system's view (requesters + motion engine)
// ---------------------------------------------------------------------------
interface move_cmd_scheduler_if;
  logic               req_auto_valid;
  logic signed [10:0] req_auto_x;
  logic signed [10:0] req_auto_y;
  logic               req_auto_ready;

  logic               req_man_valid;
  logic signed [10:0] req_man_x;
  logic signed [10:0] req_man_y;
  logic               req_man_ready;

  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [10:0] cmd_x;
  logic signed [10:0] cmd_y;
  logic               move_done;

  modport slave (
    input  req_auto_valid, req_auto_x, req_auto_y,
    output req_auto_ready,
    input  req_man_valid, req_man_x, req_man_y,
    output req_man_ready,
    output cmd_valid, cmd_x, cmd_y,
    input  cmd_ready, move_done
  );

  modport master (
    output req_auto_valid, req_auto_x, req_auto_y,
    input  req_auto_ready,
    output req_man_valid, req_man_x, req_man_y,
    input  req_man_ready,
    input  cmd_valid, cmd_x, cmd_y,
    output cmd_ready, move_done
  );
endinterface

// File: rtl/move_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// move_cmd_scheduler
// Arbitrates auto/manual target requests round-robin, clamps them to the
// legal frame, drops requests inside the deadband of the last enqueued
// target, buffers the rest in a small FIFO and dispatches them one at a time
// to the head-motion engine. After each move a frame-based settle interval
// elapses before the next dispatch; a frame-count timeout abandons a move if
// the engine never reports completion.
// Ports:
//   i_clk          : system clock
//   i_reset        : synchronous, active-high reset
//   i_vsync        : raw vsync, asynchronous to i_clk (frame tick source)
//   bus            : request / command handshake bundle (slave modport)
//   o_sched_state  : dispatch FSM state (00 IDLE, 01 ISSUE, 10 MOVING, 11 SETTLE)
//   o_fifo_count   : FIFO occupancy
//   o_drop_count   : deadband drops, saturating at 255
//   o_timeout_err  : sticky move-timeout flag
// ---------------------------------------------------------------------------
module move_cmd_scheduler #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int DEADBAND       = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_FRAMES = 180
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_vsync,
  move_cmd_scheduler_if.slave           bus,
  output logic [1:0]                    o_sched_state,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [7:0]                    o_drop_count,
  output logic                          o_timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);

  localparam logic [10:0]   X_MAX_C     = X_MAX[10:0];
  localparam logic [10:0]   Y_MAX_C     = Y_MAX[10:0];
  localparam logic [11:0]   DEADBAND_C  = DEADBAND[11:0];
  localparam logic [AW:0]   DEPTH_C     = FIFO_DEPTH[AW:0];
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_FRAMES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_MOVING = 2'b10,
    ST_SETTLE = 2'b11
  } state_t;

  // Negative coordinates pin to 0, oversize ones pin to the axis maximum.
  function automatic logic [10:0] clamp_coord(input logic [10:0] v, input logic [10:0] max_v);
    logic [10:0] r;
    if (v[10])
      r = '0;
    else if (v > max_v)
      r = max_v;
    else
      r = v;
    return r;
  endfunction

  // ---------------- registers ----------------
  logic          r_vs_meta, r_vs_sync, r_vs_prev;
  state_t        r_state;
  logic          r_cmd_valid;
  logic [10:0]   r_cmd_x, r_cmd_y;
  logic [10:0]   r_fifo_x [FIFO_DEPTH];
  logic [10:0]   r_fifo_y [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [10:0]   r_last_x, r_last_y;
  logic          r_prio_man;   // 1: manual wins the next tie
  logic [7:0]    r_drop_count;
  logic          r_timeout_err;
  logic [TW-1:0] r_frame_cnt;
  logic [SW-1:0] r_settle_cnt;

  // ---------------- wires ----------------
  logic               w_tick;
  logic               w_grant_auto, w_grant_man, w_not_full;
  logic               w_ready_auto, w_ready_man, w_accept;
  logic [10:0]        w_cx, w_cy;
  logic signed [11:0] w_dx, w_dy;
  logic [11:0]        w_adx, w_ady;
  logic               w_in_db, w_push, w_drop;
  state_t             w_state_next;
  logic               w_pop, w_cmd_valid_next, w_timeout_set;
  logic [TW-1:0]      w_frame_next;
  logic [SW-1:0]      w_settle_next;

  // Frame tick: rising edge of the synchronized vsync.
  assign w_tick = r_vs_sync & ~r_vs_prev;

  // Round-robin grant; a tie goes to whoever was not accepted last.
  assign w_grant_auto = bus.req_auto_valid & (~bus.req_man_valid | ~r_prio_man);
  assign w_grant_man  = bus.req_man_valid  & (~bus.req_auto_valid | r_prio_man);
  // Registered count only: a pop in this cycle does not make room for a push.
  assign w_not_full   = (r_count < DEPTH_C);
  assign w_ready_auto = w_grant_auto & w_not_full & ~i_reset;
  assign w_ready_man  = w_grant_man  & w_not_full & ~i_reset;
  assign w_accept     = w_ready_auto | w_ready_man;

  assign w_cx = clamp_coord(w_grant_auto ? bus.req_auto_x : bus.req_man_x, X_MAX_C);
  assign w_cy = clamp_coord(w_grant_auto ? bus.req_auto_y : bus.req_man_y, Y_MAX_C);

  assign w_dx  = $signed({1'b0, w_cx}) - $signed({1'b0, r_last_x});
  assign w_dy  = $signed({1'b0, w_cy}) - $signed({1'b0, r_last_y});
  assign w_adx = w_dx[11] ? -w_dx : w_dx;
  assign w_ady = w_dy[11] ? -w_dy : w_dy;

  assign w_in_db = (w_adx <= DEADBAND_C) & (w_ady <= DEADBAND_C);
  assign w_push  = w_accept & ~w_in_db;
  assign w_drop  = w_accept &  w_in_db;

  // ---------------- dispatch FSM, next state ----------------
  always_comb begin
    w_state_next     = r_state;
    w_pop            = 1'b0;
    w_cmd_valid_next = r_cmd_valid;
    w_frame_next     = r_frame_cnt;
    w_settle_next    = r_settle_cnt;
    w_timeout_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop            = 1'b1;
          w_cmd_valid_next = 1'b1;
          w_state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.cmd_ready) begin
          w_cmd_valid_next = 1'b0;
          w_frame_next     = '0;
          w_state_next     = ST_MOVING;
        end
      end
      ST_MOVING: begin
        // Completion takes priority over a timeout in the same cycle.
        if (bus.move_done) begin
          w_settle_next = '0;
          w_state_next  = ST_SETTLE;
        end else if (w_tick) begin
          if (r_frame_cnt == TMO_LAST) begin
            w_timeout_set = 1'b1;
            w_settle_next = '0;
            w_state_next  = ST_SETTLE;
          end else begin
            w_frame_next = r_frame_cnt + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (w_tick) begin
          if (r_settle_cnt == SETTLE_LAST)
            w_state_next = ST_IDLE;
          else
            w_settle_next = r_settle_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- FIFO storage (no reset, RAM-friendly) ----------------
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_x[r_wr_ptr] <= w_cx;
      r_fifo_y[r_wr_ptr] <= w_cy;
    end
  end

  // ---------------- state and control registers ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vs_meta     <= 1'b0;
      r_vs_sync     <= 1'b0;
      r_vs_prev     <= 1'b0;
      r_state       <= ST_IDLE;
      r_cmd_valid   <= 1'b0;
      r_cmd_x       <= '0;
      r_cmd_y       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_last_x      <= '0;
      r_last_y      <= '0;
      r_prio_man    <= 1'b0;
      r_drop_count  <= '0;
      r_timeout_err <= 1'b0;
      r_frame_cnt   <= '0;
      r_settle_cnt  <= '0;
    end else begin
      r_vs_meta    <= i_vsync;
      r_vs_sync    <= r_vs_meta;
      r_vs_prev    <= r_vs_sync;
      r_state      <= w_state_next;
      r_cmd_valid  <= w_cmd_valid_next;
      r_frame_cnt  <= w_frame_next;
      r_settle_cnt <= w_settle_next;

      if (w_pop) begin
        r_cmd_x  <= r_fifo_x[r_rd_ptr];
        r_cmd_y  <= r_fifo_y[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_last_x <= w_cx;
        r_last_y <= w_cy;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_accept)
        r_prio_man <= w_grant_auto;

      if (w_drop && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 1'b1;

      if (w_timeout_set)
        r_timeout_err <= 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign bus.req_auto_ready = w_ready_auto;
  assign bus.req_man_ready  = w_ready_man;
  assign bus.cmd_valid      = r_cmd_valid;
  assign bus.cmd_x          = r_cmd_x;
  assign bus.cmd_y          = r_cmd_y;
  assign o_sched_state      = r_state;
  assign o_fifo_count       = r_count;
  assign o_drop_count       = r_drop_count;
  assign o_timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_move_cmd_scheduler
// Directed bench for move_cmd_scheduler. Expected commands are queued when
// the corresponding request is issued; a negedge monitor pops and compares
// on every command handshake. Status outputs are checked at fixed points.
// ---------------------------------------------------------------------------
module tb_move_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [1:0] sched_state;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;
  logic       timeout_err;

  always #5 clk = ~clk;

  move_cmd_scheduler_if bus();

  move_cmd_scheduler dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_vsync       (vsync),
    .bus           (bus.slave),
    .o_sched_state (sched_state),
    .o_fifo_count  (fifo_count),
    .o_drop_count  (drop_count),
    .o_timeout_err (timeout_err)
  );

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic set_auto(input logic v, input int x, input int y);
    bus.req_auto_valid = v;
    bus.req_auto_x     = x[10:0];
    bus.req_auto_y     = y[10:0];
  endtask

  task automatic set_man(input logic v, input int x, input int y);
    bus.req_man_valid = v;
    bus.req_man_x     = x[10:0];
    bus.req_man_y     = y[10:0];
  endtask

  task automatic expect_cmd(input int x, input int y);
    cmd_t e;
    e.x = x[10:0];
    e.y = y[10:0];
    exp_q.push_back(e);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    step(4);
    vsync = 1'b0;
    step(4);
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string name);
    int k;
    k = 0;
    while ((sched_state !== s) && (k < lim)) begin
      step(1);
      k++;
    end
    check(name, 32'(sched_state), 32'(s));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    cmd_t e;
    if ((reset === 1'b0) && (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL cmd_unexpected: got (%0d,%0d) required no command", bus.cmd_x, bus.cmd_y);
      end else begin
        e = exp_q.pop_front();
        if ((bus.cmd_x !== e.x) || (bus.cmd_y !== e.y)) begin
          n_err++;
          $display("FAIL cmd_xy: got (%0d,%0d) required (%0d,%0d)", bus.cmd_x, bus.cmd_y, e.x, e.y);
        end else begin
          $display("ok   cmd_xy: (%0d,%0d)", bus.cmd_x, bus.cmd_y);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [1:0] grant_exp [8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};

  initial begin
    reset         = 1'b1;
    vsync         = 1'b0;
    set_auto(1'b0, 0, 0);
    set_man(1'b0, 0, 0);
    bus.cmd_ready = 1'b0;
    bus.move_done = 1'b0;
    step(2);

    // Reset state; a valid request during reset must not be readied.
    set_auto(1'b1, 100, 50);
    #1;
    check("rst_state", 32'(sched_state), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd_x", 32'(bus.cmd_x), 0);
    check("rst_cmd_y", 32'(bus.cmd_y), 0);
    check("rst_auto_ready", 32'(bus.req_auto_ready), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    set_auto(1'b0, 0, 0);
    step(1);
    reset = 1'b0;

    // Basic auto request and latency.
    set_auto(1'b1, 100, 50);
    #1;
    check("t1_auto_ready", 32'({bus.req_auto_ready, bus.req_man_ready}), 32'(2'b10));
    expect_cmd(100, 50);
    step(1);
    set_auto(1'b0, 0, 0);
    check("t1_n1_cmd_valid", 32'(bus.cmd_valid), 0);
    check("t1_n1_fifo_count", 32'(fifo_count), 1);
    step(1);
    check("t1_n2_cmd_valid", 32'(bus.cmd_valid), 1);
    check("t1_n2_state", 32'(sched_state), 1);
    check("t1_n2_cmd_x", 32'(bus.cmd_x), 100);
    step(2);
    check("t1_hold_valid", 32'(bus.cmd_valid), 1);
    check("t1_hold_cmd_y", 32'(bus.cmd_y), 50);
    bus.cmd_ready = 1'b1;
    step(1);
    bus.cmd_ready = 1'b0;
    check("t1_state_moving", 32'(sched_state), 2);
    check("t1_valid_low", 32'(bus.cmd_valid), 0);

    // Clamp, then deadband drop, while the engine is busy.
    set_auto(1'b1, -20, 700);
    #1;
    check("t3_auto_ready", 32'(bus.req_auto_ready), 1);
    expect_cmd(0, 479);
    step(1);
    set_auto(1'b0, 0, 0);
    set_man(1'b1, 2, 478);
    #1;
    check("t3_man_ready", 32'(bus.req_man_ready), 1);
    check("t3_count_after_first", 32'(fifo_count), 1);
    step(1);
    set_man(1'b0, 0, 0);
    check("t3_count_unchanged", 32'(fifo_count), 1);
    check("t3_drop_count", 32'(drop_count), 1);

    // move_done -> SETTLE -> two frame ticks -> IDLE -> next command.
    bus.move_done = 1'b1;
    step(1);
    bus.move_done = 1'b0;
    check("t4_settle", 32'(sched_state), 3);
    vsync_pulse();
    check("t4_settle_after_1tick", 32'(sched_state), 3);
    vsync = 1'b1;
    wait_state(2'b00, 10, "t4_idle_after_2ticks");
    step(1);
    vsync = 1'b0;
    check("t4_next_cmd_valid", 32'(bus.cmd_valid), 1);
    check("t4_next_cmd_y", 32'(bus.cmd_y), 479);
    bus.cmd_ready = 1'b1;
    step(1);
    bus.cmd_ready = 1'b0;
    check("t5_moving", 32'(sched_state), 2);
    step(2);

    // Timeout after 180 ticks without move_done.
    repeat (179) vsync_pulse();
    check("t5_no_err_at_179", 32'(timeout_err), 0);
    check("t5_still_moving", 32'(sched_state), 2);
    vsync = 1'b1;
    wait_state(2'b11, 10, "t5_settle_on_timeout");
    check("t5_timeout_err", 32'(timeout_err), 1);
    vsync = 1'b0;
    step(2);
    vsync_pulse();
    vsync_pulse();
    wait_state(2'b00, 10, "t5_idle");
    bus.move_done = 1'b1;
    step(1);
    bus.move_done = 1'b0;
    check("t5_done_ignored_state", 32'(sched_state), 0);
    check("t5_err_sticky", 32'(timeout_err), 1);

    // Both requesters every cycle with a stalled engine.
    for (int k = 0; k < 8; k++) begin
      set_auto(1'b1, 100 + 40 * k, 100);
      set_man(1'b1, 120 + 40 * k, 200);
      #1;
      check($sformatf("t2_grant_%0d", k), 32'({bus.req_auto_ready, bus.req_man_ready}), 32'(grant_exp[k]));
      if (grant_exp[k] == 2'b10) expect_cmd(100 + 40 * k, 100);
      if (grant_exp[k] == 2'b01) expect_cmd(120 + 40 * k, 200);
      if (k >= 5) check($sformatf("t2_full_%0d", k), 32'(fifo_count), 4);
      step(1);
    end
    set_auto(1'b0, 0, 0);
    set_man(1'b0, 0, 0);
    check("t2_state_issue", 32'(sched_state), 1);
    bus.cmd_ready = 1'b1;
    step(1);
    bus.cmd_ready = 1'b0;
    check("t6_pre_moving", 32'(sched_state), 2);
    check("t6_pre_count", 32'(fifo_count), 4);

    // Reset in the middle of a move with entries queued.
    reset = 1'b1;
    step(1);
    check("t6_state", 32'(sched_state), 0);
    check("t6_fifo_count", 32'(fifo_count), 0);
    check("t6_cmd_valid", 32'(bus.cmd_valid), 0);
    check("t6_timeout_err", 32'(timeout_err), 0);
    check("t6_drop_count", 32'(drop_count), 0);
    reset = 1'b0;
    exp_q.delete();
    bus.cmd_ready = 1'b1;
    step(6);
    check("t6_no_dispatch", 32'(bus.cmd_valid), 0);
    bus.cmd_ready = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
